// File: rtl/env_snapshot_reader.sv
// Reads every environment cell once in raster order (x fastest) and streams
// each cell's sugar/signal, tagged with its coordinates, through a small FIFO.
module env_snapshot_reader #(
   parameter int unsigned X_bits      = 8,
   parameter int unsigned Y_bits      = 7,
   parameter int unsigned SIGNAL_bits = 4,
   parameter int unsigned X_cells     = 160,
   parameter int unsigned Y_cells     = 120,
   parameter int unsigned FIFO_depth  = 4
) (
   input  logic                   newLocClock,
   input  logic                   RESET_SIM,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic [X_bits-1:0]      lookup_X,
   output logic [Y_bits-1:0]      lookup_Y,
   input  logic                   lookup_sugar,
   input  logic [SIGNAL_bits-1:0] lookup_signal,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [X_bits-1:0]      out_x,
   output logic [Y_bits-1:0]      out_y,
   output logic                   out_sugar,
   output logic [SIGNAL_bits-1:0] out_signal,
   output logic                   out_last
);

   localparam int unsigned PTR_W = $clog2(FIFO_depth);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [X_bits-1:0] X_LAST = X_bits'(X_cells - 1);
   localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(Y_cells - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]             state, state_next;
   logic [X_bits-1:0]      scan_x, scan_x_next;
   logic [Y_bits-1:0]      scan_y, scan_y_next;
   logic                   inflight;
   logic                   last_taken;
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       count, count_next;
   logic                   issue_c, room_c, push_c, pop_c, flush_c, at_end_c;

   logic [X_bits-1:0]      mem_x      [FIFO_depth];
   logic [Y_bits-1:0]      mem_y      [FIFO_depth];
   logic                   mem_sugar  [FIFO_depth];
   logic [SIGNAL_bits-1:0] mem_signal [FIFO_depth];

   // FIFO head drives the beat fields directly; entries stay put until popped
   assign out_x      = mem_x[rd_ptr];
   assign out_y      = mem_y[rd_ptr];
   assign out_sugar  = mem_sugar[rd_ptr];
   assign out_signal = mem_signal[rd_ptr];
   assign out_last   = (out_x == X_LAST) && (out_y == Y_LAST);

   assign push_c   = inflight;
   assign pop_c    = (count != '0) && out_ready;
   assign flush_c  = abort && (state != S_IDLE);
   assign at_end_c = (scan_x == X_LAST) && (scan_y == Y_LAST);
   // Outstanding entries (buffered + in flight) never exceed the FIFO depth
   assign room_c   = (count + CNT_W'(inflight)) < CNT_W'(FIFO_depth);
   assign count_next = count + CNT_W'(push_c) - CNT_W'(pop_c);

   // Next-state and scan counter
   always_comb begin
      state_next  = state;
      scan_x_next = scan_x;
      scan_y_next = scan_y;
      issue_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_next  = S_ISSUE;
               scan_x_next = '0;
               scan_y_next = '0;
            end
         end
         S_ISSUE: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (room_c) begin
               issue_c = 1'b1;
               if (scan_x == X_LAST) begin
                  scan_x_next = '0;
                  scan_y_next = scan_y + Y_bits'(1);
               end else begin
                  scan_x_next = scan_x + X_bits'(1);
               end
               if (at_end_c) state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (!inflight && (count_next == '0) &&
                         (last_taken || (pop_c && out_last))) begin
               state_next = S_DONE;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Control, lookup address and status registers
   always_ff @(posedge newLocClock or posedge RESET_SIM) begin
      if (RESET_SIM) begin
         state      <= S_IDLE;
         scan_x     <= '0;
         scan_y     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         lookup_X   <= '0;
         lookup_Y   <= '0;
         inflight   <= 1'b0;
         last_taken <= 1'b0;
         out_valid  <= 1'b0;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state  <= state_next;
         scan_x <= scan_x_next;
         scan_y <= scan_y_next;
         busy   <= (state_next == S_ISSUE) || (state_next == S_DRAIN);
         done   <= (state_next == S_DONE);
         if (issue_c) begin
            lookup_X <= scan_x;
            lookup_Y <= scan_y;
         end
         if (flush_c) begin
            inflight   <= 1'b0;
            last_taken <= 1'b0;
            out_valid  <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
         end else begin
            inflight  <= issue_c;
            out_valid <= (count_next != '0);
            count     <= count_next;
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (state == S_IDLE)
               last_taken <= 1'b0;
            else if (pop_c && out_last)
               last_taken <= 1'b1;
         end
      end
   end

   // Data returned for the previously issued address lands in the FIFO
   always_ff @(posedge newLocClock or posedge RESET_SIM) begin
      if (RESET_SIM) begin
         for (int i = 0; i < int'(FIFO_depth); i++) begin
            mem_x[i]      <= '0;
            mem_y[i]      <= '0;
            mem_sugar[i]  <= 1'b0;
            mem_signal[i] <= '0;
         end
      end else if (push_c && !flush_c) begin
         mem_x[wr_ptr]      <= lookup_X;
         mem_y[wr_ptr]      <= lookup_Y;
         mem_sugar[wr_ptr]  <= lookup_sugar;
         mem_signal[wr_ptr] <= lookup_signal;
      end
   end

endmodule

// File: tb/tb_env_snapshot_reader.sv
// Randomized bench for env_snapshot_reader: raster-order reference model,
// backpressure, abort, start corners and asynchronous reset during drain.
module tb_env_snapshot_reader;

   localparam int unsigned XB    = 8;
   localparam int unsigned YB    = 7;
   localparam int unsigned SB    = 4;
   localparam int unsigned XC    = 160;
   localparam int unsigned YC    = 120;
   localparam int unsigned FD    = 4;
   localparam int          CELLS = XC * YC;

   logic          clk = 1'b0;
   logic          rst, start, abort, busy, done;
   logic [XB-1:0] lookup_X, out_x;
   logic [YB-1:0] lookup_Y, out_y;
   logic          lookup_sugar, out_sugar, out_valid, out_ready, out_last;
   logic [SB-1:0] lookup_signal, out_signal;

   env_snapshot_reader #(
      .X_bits(XB), .Y_bits(YB), .SIGNAL_bits(SB),
      .X_cells(XC), .Y_cells(YC), .FIFO_depth(FD)
   ) dut (
      .newLocClock(clk), .RESET_SIM(rst), .start(start), .abort(abort),
      .busy(busy), .done(done), .lookup_X(lookup_X), .lookup_Y(lookup_Y),
      .lookup_sugar(lookup_sugar), .lookup_signal(lookup_signal),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
      .out_y(out_y), .out_sugar(out_sugar), .out_signal(out_signal),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Environment memory: data for the presented address within the same cycle
   assign lookup_sugar  = (int'(lookup_X) == int'(lookup_Y));
   assign lookup_signal = lookup_X[3:0] ^ lookup_Y[3:0];

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          exp_k, t_start, first_cyc, done_cnt, done_cyc, g;
   logic        stalled;
   logic [20:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Beat k of a snapshot: raster order, x fastest
   function automatic logic [20:0] model(input int k);
      int x, y;
      x = k % XC;
      y = k / XC;
      return {XB'(x), YB'(y), 1'(x == y), SB'(x ^ y), 1'(k == CELLS - 1)};
   endfunction

   // One clock: drive ready for the coming edge, then observe the stream
   task automatic tick(input int ready_pct);
      logic [20:0] cur;
      int          occ;
      @(negedge clk);
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      cur = {out_x, out_y, out_sugar, out_signal, out_last};
      if (stalled) check("stall_hold", 64'({out_valid, cur}), 64'({1'b1, held}));
      if (out_valid) begin
         if (first_cyc < 0) first_cyc = cyc - t_start;
         occ = int'(lookup_Y) * XC + int'(lookup_X) + 1 - exp_k;
         check("occupancy_le_depth", 64'(occ <= FD), 64'(1));
      end
      if (out_valid && out_ready) begin
         check("beat", 64'(cur), 64'(model(exp_k)));
         exp_k++;
      end
      stalled = out_valid && !out_ready;
      held    = cur;
      if (done) begin
         done_cnt++;
         done_cyc = cyc - t_start;
      end
   endtask

   task automatic begin_run();
      start     = 1'b1;
      t_start   = cyc;
      exp_k     = 0;
      first_cyc = -1;
      done_cnt  = 0;
      done_cyc  = -1;
      stalled   = 1'b0;
      g         = 0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      exp_k = 0; t_start = 0; first_cyc = -1; done_cnt = 0; done_cyc = -1;
      stalled = 1'b0; held = '0; g = 0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_valid", 64'(out_valid), 64'(0));
      check("reset_lookup", 64'({lookup_X, lookup_Y}), 64'(0));
      rst = 1'b0;

      // start and abort together from IDLE: abort wins
      tick(100);
      start = 1'b1; abort = 1'b1;
      tick(100);
      check("idle_start_abort_busy", 64'(busy), 64'(0));
      repeat (4) tick(100);
      check("idle_start_abort_valid", 64'(out_valid), 64'(0));

      // full grid, ready held high, with a stray start while busy
      tick(100);
      begin_run();
      while (done_cnt == 0 && g < CELLS + 50) begin
         tick(100);
         if (g == 1000) start = 1'b1;
         g++;
      end
      check("basic_done_seen", 64'(done_cnt), 64'(1));
      check("basic_beats", 64'(exp_k), 64'(CELLS));
      check("basic_first_latency", 64'(first_cyc), 64'(3));
      check("basic_done_cycle", 64'(done_cyc), 64'(CELLS + 3));
      tick(100);
      check("basic_done_pulse", 64'({done, busy}), 64'(0));
      repeat (3) tick(100);
      check("basic_done_count", 64'(done_cnt), 64'(1));

      // abort at beat 500 while stalled, then a clean restart from (0,0)
      begin_run();
      while (exp_k < 500 && g < 2000) begin tick(100); g++; end
      check("abort_reach_500", 64'(exp_k), 64'(500));
      repeat (3) tick(0);
      abort = 1'b1;
      stalled = 1'b0;
      tick(0);
      check("abort_valid", 64'(out_valid), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      repeat (10) tick(100);
      check("abort_no_done", 64'(done_cnt), 64'(0));
      begin_run();
      while (exp_k < 40 && g < 200) begin tick(100); g++; end
      check("restart_beats", 64'(exp_k), 64'(40));
      abort = 1'b1;
      stalled = 1'b0;
      tick(100);
      check("restart_abort_busy", 64'(busy), 64'(0));

      // random backpressure, ready about 30% of cycles
      tick(100);
      begin_run();
      while (exp_k < 3000 && g < 20000) begin tick(30); g++; end
      check("bp_reach_3000", 64'(exp_k), 64'(3000));
      abort = 1'b1;
      stalled = 1'b0;
      tick(100);
      check("bp_abort_busy", 64'({busy, out_valid}), 64'(0));

      // stall the tail so the block sits in DRAIN, then reset mid-cycle
      tick(100);
      begin_run();
      while (exp_k < CELLS - 3 && g < CELLS + 100) begin tick(100); g++; end
      check("drain_reach", 64'(exp_k), 64'(CELLS - 3));
      repeat (8) tick(0);
      check("drain_busy_valid", 64'({busy, out_valid}), 64'(3));
      check("drain_lookup_last", 64'({lookup_X, lookup_Y}), 64'({XB'(XC - 1), YB'(YC - 1)}));
      #2 rst = 1'b1;
      stalled = 1'b0;
      #1;
      check("async_rst_status", 64'({busy, done, out_valid}), 64'(0));
      check("async_rst_lookup", 64'({lookup_X, lookup_Y}), 64'(0));
      tick(100);
      rst = 1'b0;
      repeat (30) tick(100);
      check("post_rst_no_done", 64'(done_cnt), 64'(0));
      check("post_rst_idle", 64'({busy, out_valid}), 64'(0));
      check("post_rst_no_beats", 64'(exp_k), 64'(CELLS - 3));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/env_snapshot_reader.md
ENV_SNAPSHOT_READER -- requirements
Module: env_snapshot_reader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- X_bits, 8, column coordinate width
- Y_bits, 7, row coordinate width
- SIGNAL_bits, 4, signal field width
- X_cells, 160, grid columns
- Y_cells, 120, grid rows
- FIFO_depth, 4, output buffer entries (power of 2, >=2)

REQ-002 Ports (name, direction, width, meaning), one per line:
- newLocClock, in, 1, sole clock, rising edge
- RESET_SIM, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle pulse that begins a full-grid snapshot
- abort, in, 1, synchronous cancel of the current snapshot
- busy, out, 1, snapshot in progress
- done, out, 1, one-cycle pulse after the final beat is accepted
- lookup_X, out, X_bits, environment lookup column
- lookup_Y, out, Y_bits, environment lookup row
- lookup_sugar, in, 1, environment sugar at the lookup address, valid 1 cycle after the address
- lookup_signal, in, SIGNAL_bits, environment signal at the lookup address, same timing as lookup_sugar
- out_valid, out, 1, stream beat valid
- out_ready, in, 1, stream sink ready
- out_x, out, X_bits, beat column
- out_y, out, Y_bits, beat row
- out_sugar, out, 1, beat sugar
- out_signal, out, SIGNAL_bits, beat signal
- out_last, out, 1, beat is cell (X_cells-1, Y_cells-1)

Function
REQ-003 Block is the read-side counterpart of the environment write sweep: reads every cell once, raster order, x fastest, (0,0) first.
REQ-004 States: IDLE, ISSUE, DRAIN, DONE.
REQ-005 IDLE: busy=0; start=1 -> ISSUE, scan counter cleared to (0,0), FIFO empty.
REQ-006 ISSUE: an address is issued in a cycle only when fifo_count + inflight < FIFO_depth; inflight is 0 or 1.
REQ-007 Issued address is registered onto lookup_X/lookup_Y; the following cycle lookup_sugar/lookup_signal, tagged with that address, are written to the FIFO unconditionally. Overflow is impossible by REQ-006.
REQ-008 Counter: x increments by 1; at x=X_cells-1, x wraps to 0 and y increments by 1. Issuing (X_cells-1, Y_cells-1) -> DRAIN.
REQ-009 DRAIN: no new issues; -> DONE when the FIFO is empty, inflight=0, and the last beat has been accepted.
REQ-010 DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-011 Stream handshake: a beat transfers when out_valid && out_ready.
- out_valid = FIFO non-empty.
- Beat fields hold stable while out_valid && !out_ready.
- No combinational path from out_ready to out_valid.
REQ-012 Same-cycle FIFO write and pop are both honoured; count is unchanged.
REQ-013 Write-through into an empty FIFO: the beat appears on out_valid the cycle after the data-capture cycle, so first-beat latency after start is 3 cycles.
REQ-014 Throughput: with out_ready held at 1, one beat per cycle sustained. Full grid of X_cells*Y_cells beats completes in X_cells*Y_cells+3 cycles from start to done.
REQ-015 start while busy=1 is ignored.
REQ-016 abort=1 in any non-IDLE state, next cycle:
- FIFO flushed, inflight cleared
- out_valid=0, done not asserted
- -> IDLE
REQ-017 abort and start in the same cycle from IDLE: abort wins; remain IDLE.
REQ-018 lookup_X/lookup_Y hold their last value when not issuing.
REQ-019 out_last is asserted only on the beat whose coordinates equal (X_cells-1, Y_cells-1).

Reset
REQ-020 RESET_SIM=1 asynchronously forces: state IDLE, counters 0, FIFO empty, inflight 0, busy=0, done=0, out_valid=0, lookup_X=0, lookup_Y=0.
REQ-021 RESET_SIM mid-snapshot discards all buffered beats; no done pulse.

Verification
REQ-022 Basic: reset, start pulse, out_ready=1, environment model returns signal=x[3:0]^y[3:0], sugar=(x==y) -> 19200 beats in raster order with matching data, out_last only on (159,119), done 19203 cycles after start.
REQ-023 Backpressure: out_ready random at 30% -> no beat lost or duplicated, fields stable while stalled, fifo_count never exceeds 4.
REQ-024 Wrap: observe beats (158,0), (159,0), (0,1) as consecutive; (159,118) followed by (0,119).
REQ-025 Abort: start; abort at beat 500 with out_ready=0 -> next cycle out_valid=0 and busy=0, no done; a new start then begins from (0,0).
REQ-026 Start/abort corners: start while busy -> sequence unaffected; start+abort together in IDLE -> busy stays 0.
REQ-027 Async reset: assert RESET_SIM mid-cycle during DRAIN -> all outputs at reset values before the next clock edge.
